// File: rtl/scan_sched_pkg.sv
// Shared types and constants for the scan_sched sounding scheduler.
// Optional feature macro used by this slice: SCAN_EXT_SYNC_EN.
package scan_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_PULSE_P,
    ST_PULSE_N,
    ST_ACQ,
    ST_NEXT
  } state_e;

  localparam logic [3:0] REG_SETTLE = 4'd8;
  localparam logic [3:0] REG_HALF   = 4'd9;
  localparam logic [3:0] REG_ACQ    = 4'd10;
  localparam logic [3:0] REG_PERIOD = 4'd11;

  localparam int SEL0_LSB = 0;
  localparam int SEL1_LSB = 3;
  localparam int ELEM_LSB = 6;
  localparam int CH_BIT   = 9;
  localparam int EN_BIT   = 10;

  localparam logic [15:0] DEF_SETTLE = 16'd4;
  localparam logic [15:0] DEF_HALF   = 16'd8;
  localparam logic [15:0] DEF_ACQ    = 16'd1024;
  localparam logic [15:0] DEF_PERIOD = 16'd50000;

  typedef struct packed {
    logic       en;
    logic       ch;
    logic [2:0] elem;
    logic [2:0] sel1;
    logic [2:0] sel0;
  } entry_t;

  // First timed state of a tact (or of its remainder), skipping zero lengths.
  function automatic state_e first_state(input logic has_settle, input logic has_half,
                                         input logic has_acq);
    if (has_settle)   return ST_SETTLE;
    else if (has_half) return ST_PULSE_P;
    else if (has_acq)  return ST_ACQ;
    else               return ST_NEXT;
  endfunction

endpackage

// File: rtl/scan_sched_trig.sv
// Frame trigger source: internal period counter, or the synchronised external
// sync edge when SCAN_EXT_SYNC_EN is defined. trig is a registered one-cycle pulse.
module scan_trig #(
  parameter int CNT_W = 16
) (
  input  logic             adc_clk,
  input  logic             rst,
  input  logic             i_run,
`ifdef SCAN_EXT_SYNC_EN
  input  logic             i_sync,
`else
  input  logic [CNT_W-1:0] period,
`endif
  output logic             trig
);

`ifdef SCAN_EXT_SYNC_EN
  // [0],[1] are the synchroniser, [2] remembers the previous level for edge detect.
  logic [2:0] sync_q;

  always_ff @(posedge adc_clk) begin
    if (rst) begin
      sync_q <= '0;
      trig   <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], i_sync};
      trig   <= i_run & sync_q[1] & ~sync_q[2];
    end
  end
`else
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge adc_clk) begin
    if (rst || !i_run || period == '0) begin
      cnt_q <= '0;
      trig  <= 1'b0;
    end else if (cnt_q >= period - 1'b1) begin
      cnt_q <= '0;
      trig  <= 1'b1;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      trig  <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/scan_sched.sv
// Sounding scheduler: per frame walks the tact table, selects inputs, fires one
// bipolar pulse and opens the ADC window. Macro SCAN_EXT_SYNC_EN selects external sync.
module scan_sched
  import scan_sched_pkg::*;
#(
  parameter int TACTS = 8,
  parameter int CNT_W = 16
) (
  input  logic        adc_clk,
  input  logic        rst,
  input  logic        i_cfg_we,
  input  logic [3:0]  i_cfg_addr,
  input  logic [15:0] i_cfg_data,
  input  logic        i_run,
`ifdef SCAN_EXT_SYNC_EN
  input  logic        i_sync,
`endif
  output logic [2:0]  o_sel_0,
  output logic [2:0]  o_sel_1,
  output logic [7:0]  o_pulse_p_0,
  output logic [7:0]  o_pulse_n_0,
  output logic [7:0]  o_pulse_p_1,
  output logic [7:0]  o_pulse_n_1,
  output logic        o_acq,
  output logic [2:0]  o_tact,
  output logic        o_busy,
  output logic        o_frame_done,
  output logic        o_overrun
);

  localparam logic [3:0]       TACTS_A   = 4'(TACTS);
  localparam logic [2:0]       LAST_TACT = 3'(TACTS - 1);
  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

  entry_t           table_q [8];
  logic [CNT_W-1:0] settle_q, half_q, acq_q;
  logic [CNT_W-1:0] sh_settle_q, sh_half_q, sh_acq_q;
  logic [CNT_W-1:0] eff_settle, eff_half, eff_acq, len_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_e           state_q, state_d;
  logic [2:0]       tact_q, tact_d, start_tact;
  entry_t           entry_q, entry_d;
  logic             start, trig;
  logic             has_settle, has_half, has_acq;
  logic [7:0]       elem_hot;

`ifdef SCAN_EXT_SYNC_EN
  scan_trig #(.CNT_W(CNT_W)) u_trig (
    .adc_clk (adc_clk),
    .rst     (rst),
    .i_run   (i_run),
    .i_sync  (i_sync),
    .trig    (trig)
  );
`else
  logic [CNT_W-1:0] period_q;

  scan_trig #(.CNT_W(CNT_W)) u_trig (
    .adc_clk (adc_clk),
    .rst     (rst),
    .i_run   (i_run),
    .period  (period_q),
    .trig    (trig)
  );
`endif

  // Shadows follow the live registers while idle and freeze for the whole frame.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      // NOTE: the table is reset because entries must read back as disabled after
      // rst; it is tiny, a large RAM would normally be left unreset.
      for (int i = 0; i < 8; i++) table_q[i] <= '0;
      settle_q    <= CNT_W'(DEF_SETTLE);
      half_q      <= CNT_W'(DEF_HALF);
      acq_q       <= CNT_W'(DEF_ACQ);
      sh_settle_q <= CNT_W'(DEF_SETTLE);
      sh_half_q   <= CNT_W'(DEF_HALF);
      sh_acq_q    <= CNT_W'(DEF_ACQ);
`ifndef SCAN_EXT_SYNC_EN
      period_q    <= CNT_W'(DEF_PERIOD);
`endif
    end else begin
      if (i_cfg_we) begin
        if (i_cfg_addr < TACTS_A) begin
          table_q[i_cfg_addr[2:0]] <= '{en:   i_cfg_data[EN_BIT],
                                        ch:   i_cfg_data[CH_BIT],
                                        elem: i_cfg_data[ELEM_LSB +: 3],
                                        sel1: i_cfg_data[SEL1_LSB +: 3],
                                        sel0: i_cfg_data[SEL0_LSB +: 3]};
        end else begin
          case (i_cfg_addr)
            REG_SETTLE: settle_q <= CNT_W'(i_cfg_data);
            REG_HALF:   half_q   <= CNT_W'(i_cfg_data);
            REG_ACQ:    acq_q    <= CNT_W'(i_cfg_data);
`ifndef SCAN_EXT_SYNC_EN
            REG_PERIOD: period_q <= CNT_W'(i_cfg_data);
`endif
            default: ;
          endcase
        end
      end
      if (state_q == ST_IDLE) begin
        sh_settle_q <= settle_q;
        sh_half_q   <= half_q;
        sh_acq_q    <= acq_q;
      end
    end
  end

  assign eff_settle = (state_q == ST_IDLE) ? settle_q : sh_settle_q;
  assign eff_half   = (state_q == ST_IDLE) ? half_q   : sh_half_q;
  assign eff_acq    = (state_q == ST_IDLE) ? acq_q    : sh_acq_q;
  assign has_settle = (eff_settle != '0);
  assign has_half   = (eff_half != '0);
  assign has_acq    = (eff_acq != '0);

  always_comb begin
    // NOTE: every variable gets a default first so no path can infer a latch.
    state_d    = state_q;
    tact_d     = tact_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    start      = 1'b0;
    start_tact = '0;
    len_d      = ONE;

    case (state_q)
      ST_IDLE:    if (trig) start = 1'b1;
      ST_SETTLE:  if (cnt_q == ONE) state_d = first_state(1'b0, has_half, has_acq);
      ST_PULSE_P: if (cnt_q == ONE) state_d = ST_PULSE_N;
      ST_PULSE_N: if (cnt_q == ONE) state_d = first_state(1'b0, 1'b0, has_acq);
      ST_ACQ:     if (cnt_q == ONE) state_d = ST_NEXT;
      ST_NEXT: begin
        if (tact_q == LAST_TACT) begin
          state_d = ST_IDLE;
          tact_d  = '0;
        end else begin
          start      = 1'b1;
          start_tact = tact_q + 3'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A tact reads its entry only at the moment it starts.
    if (start) begin
      tact_d  = start_tact;
      entry_d = table_q[start_tact];
      state_d = entry_d.en ? first_state(has_settle, has_half, has_acq) : ST_NEXT;
    end

    case (state_d)
      ST_SETTLE:              len_d = eff_settle;
      ST_PULSE_P, ST_PULSE_N: len_d = eff_half;
      ST_ACQ:                 len_d = eff_acq;
      default:                len_d = ONE;
    endcase

    if (state_d != state_q) cnt_d = len_d;
    else if (cnt_q > ONE)   cnt_d = cnt_q - ONE;
  end

  assign elem_hot = 8'b1 << entry_d.elem;

  // Outputs are registered from the next-state values so they align with the state.
  always_ff @(posedge adc_clk) begin
    if (rst) begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      state_q      <= ST_IDLE;
      tact_q       <= '0;
      cnt_q        <= '0;
      entry_q      <= '0;
      o_sel_0      <= '0;
      o_sel_1      <= '0;
      o_pulse_p_0  <= '0;
      o_pulse_n_0  <= '0;
      o_pulse_p_1  <= '0;
      o_pulse_n_1  <= '0;
      o_acq        <= 1'b0;
      o_tact       <= '0;
      o_busy       <= 1'b0;
      o_frame_done <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state_q      <= state_d;
      tact_q       <= tact_d;
      cnt_q        <= cnt_d;
      entry_q      <= entry_d;
      if (start && entry_d.en) begin
        o_sel_0 <= entry_d.sel0;
        o_sel_1 <= entry_d.sel1;
      end
      o_pulse_p_0  <= (state_d == ST_PULSE_P && !entry_d.ch) ? elem_hot : 8'h00;
      o_pulse_n_0  <= (state_d == ST_PULSE_N && !entry_d.ch) ? elem_hot : 8'h00;
      o_pulse_p_1  <= (state_d == ST_PULSE_P &&  entry_d.ch) ? elem_hot : 8'h00;
      o_pulse_n_1  <= (state_d == ST_PULSE_N &&  entry_d.ch) ? elem_hot : 8'h00;
      o_acq        <= (state_d == ST_ACQ);
      o_tact       <= tact_d;
      o_busy       <= (state_d != ST_IDLE);
      o_frame_done <= (state_d == ST_NEXT) && (tact_d == LAST_TACT);
      o_overrun    <= trig && (state_q != ST_IDLE);
    end
  end

endmodule

// File: tb/tb_scan_sched.sv
// Directed self-checking bench for scan_sched; the SCAN_EXT_SYNC_EN build runs
// the external-sync scenario instead of the period-counter scenarios.
module tb_scan_sched;
  import scan_sched_pkg::*;

  logic        adc_clk = 1'b0;
  logic        rst, i_cfg_we, i_run, i_sync;
  logic [3:0]  i_cfg_addr;
  logic [15:0] i_cfg_data;
  logic [2:0]  o_sel_0, o_sel_1, o_tact;
  logic [7:0]  o_pulse_p_0, o_pulse_n_0, o_pulse_p_1, o_pulse_n_1;
  logic        o_acq, o_busy, o_frame_done, o_overrun;

  int checks = 0;
  int errors = 0;

  // Per-frame measurements filled by measure_frame.
  int f_len, p0_cnt, n0_cnt, p1_cnt, n1_cnt, acq_cnt, done_cnt, done_idx, ovr_cnt;
  int overlap, bad_pulse, first_p, first_acq, tact_steps, tact_bad;
  logic [2:0] sel0_first, sel1_first, sel0_last, prev_tact;
  logic [7:0] exp_p0, exp_p1;

  scan_sched dut (
    .adc_clk      (adc_clk),
    .rst          (rst),
    .i_cfg_we     (i_cfg_we),
    .i_cfg_addr   (i_cfg_addr),
    .i_cfg_data   (i_cfg_data),
    .i_run        (i_run),
`ifdef SCAN_EXT_SYNC_EN
    .i_sync       (i_sync),
`endif
    .o_sel_0      (o_sel_0),
    .o_sel_1      (o_sel_1),
    .o_pulse_p_0  (o_pulse_p_0),
    .o_pulse_n_0  (o_pulse_n_0),
    .o_pulse_p_1  (o_pulse_p_1),
    .o_pulse_n_1  (o_pulse_n_1),
    .o_acq        (o_acq),
    .o_tact       (o_tact),
    .o_busy       (o_busy),
    .o_frame_done (o_frame_done),
    .o_overrun    (o_overrun)
  );

  always #5 adc_clk = ~adc_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic cfg_write(input logic [3:0] addr, input logic [15:0] data);
    @(negedge adc_clk);
    i_cfg_we   = 1'b1;
    i_cfg_addr = addr;
    i_cfg_data = data;
    @(negedge adc_clk);
    i_cfg_we   = 1'b0;
  endtask

  // Waits for a frame, then samples every busy cycle; optionally writes one
  // register at busy-cycle index wr_at.
  task automatic measure_frame(input int wr_at, input logic [3:0] wa, input logic [15:0] wd);
    int n;
    n = 0;
    while (!o_busy && n < 3000) begin
      @(negedge adc_clk);
      n++;
    end
    check("frame_start_timeout", 32'(n < 3000), 32'd1);
    {f_len, p0_cnt, n0_cnt, p1_cnt, n1_cnt, acq_cnt, done_cnt, ovr_cnt} = '0;
    {overlap, bad_pulse, tact_steps, tact_bad} = '0;
    done_idx = -1; first_p = -1; first_acq = -1;
    sel0_first = o_sel_0; sel1_first = o_sel_1; prev_tact = o_tact;
    while (o_busy && f_len < 3000) begin
      if (f_len == wr_at) begin
        i_cfg_we = 1'b1; i_cfg_addr = wa; i_cfg_data = wd;
      end else begin
        i_cfg_we = 1'b0;
      end
      if (o_pulse_p_0 != 0) p0_cnt++;
      if (o_pulse_n_0 != 0) n0_cnt++;
      if (o_pulse_p_1 != 0) p1_cnt++;
      if (o_pulse_n_1 != 0) n1_cnt++;
      if ((o_pulse_p_0 != 0 && o_pulse_p_0 != exp_p0) || (o_pulse_n_0 != 0 && o_pulse_n_0 != exp_p0) ||
          (o_pulse_p_1 != 0 && o_pulse_p_1 != exp_p1) || (o_pulse_n_1 != 0 && o_pulse_n_1 != exp_p1))
        bad_pulse++;
      if ((o_pulse_p_0 != 0 || o_pulse_p_1 != 0) && (o_pulse_n_0 != 0 || o_pulse_n_1 != 0)) overlap++;
      if (first_p < 0 && (o_pulse_p_0 != 0 || o_pulse_p_1 != 0)) first_p = f_len;
      if (o_acq) begin
        acq_cnt++;
        if (first_acq < 0) first_acq = f_len;
      end
      if (o_frame_done) begin done_cnt++; done_idx = f_len; end
      if (o_overrun) ovr_cnt++;
      if (o_tact != prev_tact) begin
        tact_steps++;
        if (o_tact != prev_tact + 3'd1) tact_bad++;
        prev_tact = o_tact;
      end
      sel0_last = o_sel_0;
      f_len++;
      @(negedge adc_clk);
    end
    i_cfg_we = 1'b0;
    check("frame_end_timeout", 32'(f_len < 3000), 32'd1);
  endtask

  initial begin
    int n;
    rst = 1'b1; i_cfg_we = 1'b0; i_cfg_addr = '0; i_cfg_data = '0; i_run = 1'b0; i_sync = 1'b0;
    exp_p0 = 8'h04; exp_p1 = 8'h00;
    repeat (3) @(negedge adc_clk);
    check("rst_busy", 32'(o_busy), 32'd0);
    check("rst_tact", 32'(o_tact), 32'd0);
    check("rst_outs", 32'(|{o_sel_0, o_sel_1, o_pulse_p_0, o_pulse_n_0, o_pulse_p_1, o_pulse_n_1,
                            o_acq, o_frame_done, o_overrun}), 32'd0);
    rst = 1'b0;

`ifdef SCAN_EXT_SYNC_EN
    cfg_write(4'd0, 16'h04AB);
    i_run = 1'b1;
    @(negedge adc_clk);
    i_sync = 1'b1;
    n = 0;
    while (!o_busy && n < 10) begin
      @(negedge adc_clk);
      n++;
    end
    check("sync_latency_3_to_4", 32'(n >= 3 && n <= 4), 32'd1);
    repeat (50) @(negedge adc_clk);
    i_sync = 1'b0;
    repeat (10) @(negedge adc_clk);
    i_sync = 1'b1;
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge adc_clk);
      if (o_overrun) n++;
    end
    check("sync_overrun", 32'(n), 32'd1);
    check("sync_still_busy", 32'(o_busy), 32'd1);
    i_run = 1'b0;
`else
    // Frame with defaults: tact 0 only, 4 + 2*8 + 1024 + 1 + 7 = 1052 cycles.
    cfg_write(4'd0, 16'h04AB);
    cfg_write(REG_PERIOD, 16'd200);
    i_run = 1'b1;
    measure_frame(-1, 4'd0, 16'd0);
    check("t1_len", 32'(f_len), 32'd1052);
    check("t1_sel0", 32'(sel0_first), 32'd3);
    check("t1_sel1", 32'(sel1_first), 32'd5);
    check("t1_first_p", 32'(first_p), 32'd4);
    check("t1_p_cycles", 32'(p0_cnt), 32'd8);
    check("t1_n_cycles", 32'(n0_cnt), 32'd8);
    check("t1_ch1_pulses", 32'(p1_cnt + n1_cnt), 32'd0);
    check("t1_first_acq", 32'(first_acq), 32'd20);
    check("t1_acq_cycles", 32'(acq_cnt), 32'd1024);
    check("t1_pulse_value", 32'(bad_pulse), 32'd0);
    check("t1_p_n_overlap", 32'(overlap), 32'd0);
    check("t1_done_idx", 32'(done_idx), 32'd1051);
    check("t1_overruns", 32'(ovr_cnt), 32'd5);
    i_run = 1'b0;
    n = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge adc_clk);
      if (o_busy) n++;
    end
    check("t1_run_low_idle", 32'(n), 32'd0);

    // Tacts 0 and 2 enabled: (2+6+10+1)*2 + 6 = 44; acq=20 written mid-frame.
    cfg_write(REG_SETTLE, 16'd2);
    cfg_write(REG_HALF, 16'd3);
    cfg_write(REG_ACQ, 16'd10);
    cfg_write(4'd2, 16'h0751);
    cfg_write(REG_PERIOD, 16'd500);
    exp_p1 = 8'h20;
    i_run = 1'b1;
    measure_frame(5, REG_ACQ, 16'd20);
    check("t2_len", 32'(f_len), 32'd44);
    check("t2_done_cnt", 32'(done_cnt), 32'd1);
    check("t2_done_idx", 32'(done_idx), 32'd43);
    check("t2_tact_steps", 32'(tact_steps), 32'd7);
    check("t2_tact_order", 32'(tact_bad), 32'd0);
    check("t2_p0_cycles", 32'(p0_cnt), 32'd3);
    check("t2_p1_cycles", 32'(p1_cnt), 32'd3);
    check("t2_pulse_value", 32'(bad_pulse), 32'd0);
    check("t2_acq_cycles", 32'(acq_cnt), 32'd20);
    check("t2_sel0_kept", 32'(sel0_last), 32'd1);
    check("t2_overruns", 32'(ovr_cnt), 32'd0);
    measure_frame(-1, 4'd0, 16'd0);
    check("t2_next_len", 32'(f_len), 32'd64);
    check("t2_next_acq", 32'(acq_cnt), 32'd40);

    // Half = 0: no pulses, acquisition opens straight after settle.
    cfg_write(REG_HALF, 16'd0);
    measure_frame(-1, 4'd0, 16'd0);
    check("t3_len", 32'(f_len), 32'd52);
    check("t3_no_pulse", 32'(p0_cnt + n0_cnt + p1_cnt + n1_cnt), 32'd0);
    check("t3_first_acq", 32'(first_acq), 32'd2);
    cfg_write(REG_HALF, 16'd3);

    // Reset while PULSE_P is active.
    n = 0;
    while (o_pulse_p_0 == 0 && n < 1000) begin
      @(negedge adc_clk);
      n++;
    end
    check("t4_pulse_timeout", 32'(n < 1000), 32'd1);
    rst = 1'b1;
    i_run = 1'b0;
    @(negedge adc_clk);
    check("t4_rst_busy", 32'(o_busy), 32'd0);
    check("t4_rst_outs", 32'(|{o_sel_0, o_sel_1, o_pulse_p_0, o_pulse_n_0, o_pulse_p_1, o_pulse_n_1,
                               o_acq, o_tact, o_frame_done, o_overrun}), 32'd0);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge adc_clk);
      if (o_busy) n++;
    end
    check("t4_idle_after_rst", 32'(n), 32'd0);
    cfg_write(4'd0, 16'h04AB);
    cfg_write(REG_PERIOD, 16'd300);
    exp_p1 = 8'h00;
    i_run = 1'b1;
    measure_frame(-1, 4'd0, 16'd0);
    check("t4_def_len", 32'(f_len), 32'd1052);
    check("t4_def_first_p", 32'(first_p), 32'd4);
    check("t4_def_p_cycles", 32'(p0_cnt), 32'd8);
    check("t4_def_acq", 32'(acq_cnt), 32'd1024);
    check("t4_def_overruns", 32'(ovr_cnt), 32'd3);
    i_run = 1'b0;
`endif

    repeat (2) @(negedge adc_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/scan_sched.md
# scan_sched

Sounding scheduler for the two-channel ultrasonic front end. Each frame it runs a programmable table of up to 8 tacts. For each tact it drives the channel input selects, fires one bipolar pulse on one pulser element, then opens an ADC acquisition window. Frames start from an internal period counter or from the external sync input. The block sits between the ESP32 register interface (config writes) and the pulser/select pins plus the ADC capture logic.

## Interface
- TACTS, 8, number of table entries (power of two, max 8)
- CNT_W, 16, width of all duration/period counters
- adc_clk  in  1  sole clock, same domain as the ADC/DAC clocks
- rst  in  1  reset, synchronous, active-high
- i_cfg_we  in  1  config write strobe, one cycle per write
- i_cfg_addr  in  4  register address
- i_cfg_data  in  16  write data
- i_run  in  1  enables frame triggering; low stops new frames only
- i_sync  in  1  external frame sync, asynchronous (present only with SCAN_EXT_SYNC_EN)
- o_sel_0 / o_sel_1  out  3  channel 0/1 input select
- o_pulse_p_0 / o_pulse_n_0  out  8  channel 0 pulser phases, active-high, one-hot
- o_pulse_p_1 / o_pulse_n_1  out  8  channel 1 pulser phases, active-high, one-hot
- o_acq  out  1  acquisition window, capture ADC while high
- o_tact  out  3  index of the current tact
- o_busy  out  1  frame in progress
- o_frame_done  out  1  one-cycle pulse at frame end
- o_overrun  out  1  one-cycle pulse when a trigger arrives while busy

## Operation
- Register map:
  - 0..7: tact entry. Bits [2:0] sel0, [5:3] sel1, [8:6] element, [9] channel (0/1), [10] enable.
  - 8: settle length.
  - 9: half-pulse length.
  - 10: acq length.
  - 11: frame period.
  - Addresses 12..15: writes ignored.
- Reset defaults: table 0 (all disabled), settle 4, half 8, acq 1024, period 50000.
- Registers 8–11 are copied to shadow registers at frame start. Mid-frame writes to 8–11 take effect from the next frame.
- A table entry is read when its tact starts. A write to an entry takes effect if it lands before that tact starts.
- FSM states and transitions:
  - IDLE: on trigger → SETTLE, tact 0.
  - SETTLE: o_sel_x hold the entry values.
  - PULSE_P: o_pulse_p_<ch>[element] = 1.
  - PULSE_N: o_pulse_n_<ch>[element] = 1.
  - ACQ: o_acq = 1.
  - NEXT: advance the tact index. From NEXT with tact = TACTS-1 → IDLE with o_frame_done = 1; otherwise → SETTLE.
- Each timed state lasts exactly its shadow length in cycles. A length of 0 skips the state.
- Disabled tact: SETTLE through ACQ are skipped (one NEXT cycle only), and o_sel_x keep their previous values.
- P and N are never high together. All pulse bits are 0 outside PULSE_P/PULSE_N.
- Internal trigger:
  - The period counter free-runs 0..period-1 while i_run = 1 and clears while i_run = 0.
  - Wrap to 0 with i_run = 1 is a trigger.
  - period = 0 produces no triggers.
- Trigger while busy: the trigger is dropped and o_overrun pulses. The frame in progress is unaffected.
- i_run falling mid-frame: the current frame completes.
- rst mid-frame: everything returns to reset values on the next edge. There is no partial pulse after reset.

## Timing
- Reset values of all outputs are 0. State is IDLE, tact 0.
- Trigger sampled in cycle T → o_busy = 1, SETTLE and o_sel_x valid at T+1.
- PULSE_P starts at T+1+settle; PULSE_N starts half cycles later; ACQ follows.
- NEXT is 1 cycle.
- Enabled tact period = settle + 2·half + acq + 1 cycles.
- o_busy falls the cycle after o_frame_done.
- All outputs are registered, with no combinational path from inputs.
- Counters are CNT_W bits, unsigned, counting down to 1. There is no wrap-around within a state.

## Configuration
- SCAN_EXT_SYNC_EN:
  - Defined: i_sync exists and is double-flop synchronised. Its rising edge is the trigger, giving 3 cycles from pin edge to trigger. Register 11 is unused and the period counter is not instantiated.
  - Undefined: i_sync is absent and the internal period counter is the only trigger.

## Structure
- Package scan_sched_pkg holds:
  - the state enum;
  - register address constants (REG_SETTLE = 8, REG_HALF = 9, REG_ACQ = 10, REG_PERIOD = 11);
  - tact entry field positions;
  - reset default values.
- Sub-module scan_trig holds the trigger source: either the period counter or the sync synchroniser plus edge detector (selected by the macro). It outputs a one-cycle trig to the FSM.

## Test plan
- Reset, then enable tact 0 only (sel0 = 3, sel1 = 5, element 2, ch 0), period 200, i_run = 1 → per frame o_sel_0 = 3, o_sel_1 = 5, o_pulse_p_0 = 8'h04 for 8 cycles, o_pulse_n_0 = 8'h04 for 8 cycles, o_acq high 1024 cycles; o_overrun pulses because the frame is longer than the period.
- Settle 2, half 3, acq 10, tacts 0/2 enabled, 1/3..7 disabled, period 500 → frame length (2+6+10+1)·2 + 6 = 44 cycles; o_frame_done once per frame; o_tact sequence 0..7.
- Half = 0 → no pulse bits ever set; acq still opens at the settle + 0 offset.
- Write acq = 20 mid-frame → the current frame keeps the old acq; the next frame uses 20.
- Assert rst during PULSE_P → the next cycle all outputs are 0 and defaults are restored; i_run = 0 keeps the block idle.
- With SCAN_EXT_SYNC_EN: i_sync rising edge → o_busy = 1 3–4 cycles later; a second edge mid-frame → o_overrun pulse.
